lsu_mem_bridge: RTL

//  Load/store unit front end sitting directly upstream of the DPI data-memory model.

---
 rtl/npc_lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_mem_bridge.sv | 124 ++++++++++++
 3 files changed

// File: rtl/npc_lsu_pkg.sv
// Shared types for the LSU memory bridge.
//  - access size encodings (SZ_B/SZ_H/SZ_W; 2'b11 is handled as a word)
//  - bridge FSM state enum
//  - latched request fields carried from handshake to response
//  - misalignment check used at the handshake
package npc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lo;   // byte offset within the word
  } lsu_req_t;

  // Byte accesses are never misaligned. Size 2'b11 shares the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the LSU bridge.
//  Store side : st_size, st_lo, st_wdata -> st_strb (byte strobes), st_data (lane-replicated)
//  Load side  : ld_size, ld_lo, ld_uns, ld_rdata -> ld_data (right-justified, sign/zero-extended)
// The store side is fed from the live request (registered by the bridge at the
// handshake); the load side is fed from the latched request and the raw memory word.
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_uns,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] sh;
  logic        sx;

  always_comb begin
    st_strb = 4'b1111;
    st_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_strb = 4'b0001 << st_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_strb = 4'b0011 << st_lo;
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = ld_rdata >> {ld_lo, 3'b000};
  assign sx = ~ld_uns;

  always_comb begin
    ld_data = sh;
    case (ld_size)
      SZ_B:    ld_data = {{24{sx & sh[7]}},  sh[7:0]};
      SZ_H:    ld_data = {{16{sx & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU front end for the data-memory model.
//  Request  : req_valid/req_ready, req_wr, req_size, req_unsigned, req_addr, req_wdata
//  Response : resp_valid/resp_ready, resp_rdata, resp_err
//  Memory   : mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb (all registered), mem_rdata (comb)
// One access per handshake. mem_* are computed at the handshake and presented from
// flops in ACCESS, so mem_en is a clean single-cycle pulse; the memory model writes on
// every evaluation with en high, so it must never glitch or linger. Misaligned requests
// bypass the memory entirely and respond one cycle after the handshake.
module lsu_mem_bridge
  import npc_lsu_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  // WAIT lasts LAT-1 cycles; the counter runs LAT-2 .. 0.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? (LAT - 2) : 0);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  lsu_req_t         rq;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;

  lsu_align u_align (
    .st_size  (req_size),
    .st_lo    (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_strb  (st_strb),
    .st_data  (st_data),
    .ld_size  (rq.size),
    .ld_lo    (rq.lo),
    .ld_uns   (rq.uns),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rq         <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rq <= '{wr: req_wr, size: req_size, uns: req_unsigned, lo: req_addr[1:0]};
          if (misaligned(req_size, req_addr[1:0])) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= ACCESS;
            mem_en    <= 1'b1;
            mem_wr    <= req_wr;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= req_wr ? st_strb : 4'b0000;
          end
        end
        ACCESS: begin
          mem_en     <= 1'b0;
          mem_wr     <= 1'b0;
          // Memory read is combinational: capture it at the end of the access cycle.
          resp_rdata <= rq.wr ? 32'd0 : ld_data;
          if (LAT > 1) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
